// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// LOADER_CHECKSUM_EN adds the CHECK state for the trailing checksum word.
package loader_pkg;

  localparam int LOADER_HDR_BYTES  = 4;
  localparam int LOADER_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_WRITE,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERROR
  } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// UART byte-read and instruction-memory write handshakes of the program loader.
// master = loader side, slave = UART / memory side.
interface program_loader_if #(
  parameter int UART_BIT_WIDTH = 16
);

  logic                      uart_out_valid;
  logic                      uart_out_ready;
  logic [7:0]                uart_out_data;
  logic [UART_BIT_WIDTH-1:0] uart_buf_len;
  logic [31:0]               inst_mem_in_addr;
  logic [31:0]               inst_mem_in_data;
  logic                      inst_mem_in_valid;
  logic                      inst_mem_in_ready;

  modport master (
    output uart_out_valid, inst_mem_in_addr, inst_mem_in_data, inst_mem_in_valid,
    input  uart_out_ready, uart_out_data, uart_buf_len, inst_mem_in_ready
  );

  modport slave (
    input  uart_out_valid, inst_mem_in_addr, inst_mem_in_data, inst_mem_in_valid,
    output uart_out_ready, uart_out_data, uart_buf_len, inst_mem_in_ready
  );

endinterface

// File: rtl/loader_byte_fetch.sv
// Reads bytes from the UART one request at a time and assembles them
// little-endian into a 32-bit word, pulsing o_done for one cycle per word.
module loader_byte_fetch
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_avail,
  input  logic        i_ready,
  input  logic [7:0]  i_data,
  output logic        o_valid,
  output logic [31:0] o_word,
  output logic        o_done
);

  localparam int CNT_W = $clog2(LOADER_WORD_BYTES);

  logic             r_req;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_word;
  logic             w_ack;

  assign w_ack = r_req && i_ready;

  // Request drops on the acknowledge edge, so it is low for at least one cycle
  // before the next request; no new request in the done cycle, when the
  // parent may be leaving a fetching state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_word <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_ack) begin
        r_req  <= 1'b0;
        r_word <= {i_data, r_word[31:8]};
        r_cnt  <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(LOADER_WORD_BYTES - 1)) begin
          r_done <= 1'b1;
          r_cnt  <= '0;
        end
      end else if (!r_req && !r_done && i_en && i_avail) begin
        r_req <= 1'b1;
      end
    end
  end

  assign o_valid = r_req;
  assign o_word  = r_word;
  assign o_done  = r_done;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian word stream from the UART into
// instruction memory. LOADER_CHECKSUM_EN enables a trailing sum check.
module program_loader
  import loader_pkg::*;
#(
  parameter int UART_BIT_WIDTH     = 16,
  parameter int INST_MEM_BIT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.master  bus,
  output logic              load_completed,
  output logic              load_error
);

  localparam logic [32:0] MEM_WORDS = 33'd1 << (INST_MEM_BIT_WIDTH - 2);
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e ST_FINISH = ST_CHECK;
`else
  localparam loader_state_e ST_FINISH = ST_DONE;
`endif

  loader_state_e r_state;
  loader_state_e w_state_nxt;
  logic [31:0]   r_n;
  logic [31:0]   r_k;
  logic [31:0]   w_word;
  logic          w_done;
  logic          w_fetch_en;
  logic          w_uart_avail;
  logic          w_last;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   r_sum;
`endif

  assign w_uart_avail = (bus.uart_buf_len != {UART_BIT_WIDTH{1'b0}});
  assign w_last       = (r_k + 32'd1 == r_n);

  loader_byte_fetch u_fetch (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_fetch_en),
    .i_avail (w_uart_avail),
    .i_ready (bus.uart_out_ready),
    .i_data  (bus.uart_out_data),
    .o_valid (bus.uart_out_valid),
    .o_word  (w_word),
    .o_done  (w_done)
  );

  always_comb begin
    w_state_nxt           = r_state;
    w_fetch_en            = 1'b0;
    bus.inst_mem_in_valid = 1'b0;
    bus.inst_mem_in_addr  = '0;
    bus.inst_mem_in_data  = '0;
    load_completed        = 1'b0;
    load_error            = 1'b0;
    case (r_state)
      ST_LEN: begin
        w_fetch_en = 1'b1;
        if (w_done) begin
          if (w_word == 32'd0)                 w_state_nxt = ST_FINISH;
          else if ({1'b0, w_word} > MEM_WORDS) w_state_nxt = ST_ERROR;
          else                                 w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        w_fetch_en = 1'b1;
        if (w_done) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        // Fetcher is idle here, so the assembled word stays put until acked.
        bus.inst_mem_in_valid = 1'b1;
        bus.inst_mem_in_addr  = r_k << 2;
        bus.inst_mem_in_data  = w_word;
        if (bus.inst_mem_in_ready) w_state_nxt = w_last ? ST_FINISH : ST_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        w_fetch_en = 1'b1;
        if (w_done) w_state_nxt = (w_word == r_sum) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE:  load_completed = 1'b1;
      ST_ERROR: load_error     = 1'b1;
      default:  w_state_nxt    = ST_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_LEN;
      r_n     <= '0;
      r_k     <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_LEN && w_done) r_n <= w_word;
      if (r_state == ST_WRITE && bus.inst_mem_in_ready) begin
        r_k   <= r_k + 32'd1;
`ifdef LOADER_CHECKSUM_EN
        r_sum <= r_sum + w_word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: UART and memory models, expected writes
// queued by the stimulus and checked by a negedge monitor. Honors LOADER_CHECKSUM_EN.
module tb_program_loader;

  localparam int UW  = 16;
  localparam int IMW = 16;

  logic clk = 1'b0;
  logic reset;
  logic load_completed;
  logic load_error;

  always #5 clk = ~clk;

  program_loader_if #(.UART_BIT_WIDTH(UW)) bus ();

  program_loader #(.UART_BIT_WIDTH(UW), .INST_MEM_BIT_WIDTH(IMW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .load_completed (load_completed),
    .load_error     (load_error)
  );

  logic [7:0]  tx_q[$];
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;
  int n_writes = 0;
  int mem_delay = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // UART model: serves one byte per request, buf_len tracks the queue.
  initial begin
    bus.uart_out_ready = 1'b0;
    bus.uart_out_data  = 8'h00;
    bus.uart_buf_len   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.uart_out_ready = 1'b0;
        bus.uart_out_data  = 8'h00;
      end else if (bus.uart_out_valid && !bus.uart_out_ready && tx_q.size() > 0) begin
        bus.uart_out_ready = 1'b1;
        bus.uart_out_data  = tx_q.pop_front();
      end else begin
        bus.uart_out_ready = 1'b0;
        bus.uart_out_data  = 8'h00;
      end
      bus.uart_buf_len = UW'(tx_q.size());
    end
  end

  // Memory model: acknowledges after mem_delay waiting cycles.
  initial begin
    int cnt;
    cnt = 0;
    bus.inst_mem_in_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.inst_mem_in_ready = 1'b0;
        cnt = 0;
      end else if (bus.inst_mem_in_valid && !bus.inst_mem_in_ready) begin
        if (cnt >= mem_delay) begin
          bus.inst_mem_in_ready = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        bus.inst_mem_in_ready = 1'b0;
      end
    end
  end

  // Monitor: scoreboard on each write handshake plus protocol invariants.
  initial begin
    logic        p_mv, p_mr, p_uv, p_ur;
    logic [31:0] p_addr, p_data;
    logic [UW-1:0] p_len;
    logic [63:0] e;
    p_mv = 0; p_mr = 0; p_uv = 0; p_ur = 0; p_addr = 0; p_data = 0; p_len = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (bus.inst_mem_in_valid && bus.inst_mem_in_ready) begin
          n_writes++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr %h data %h required no write",
                     bus.inst_mem_in_addr, bus.inst_mem_in_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", bus.inst_mem_in_addr, e[63:32]);
            check("wr_data", bus.inst_mem_in_data, e[31:0]);
          end
        end
        if (bus.inst_mem_in_valid && p_mv && !p_mr &&
            (bus.inst_mem_in_addr != p_addr || bus.inst_mem_in_data != p_data)) viol++;
        if (bus.inst_mem_in_valid && p_mv && p_mr) viol++;
        if (!bus.inst_mem_in_valid && p_mv && !p_mr) viol++;
        if (bus.uart_out_valid && !p_uv && p_len == '0) viol++;
        if (bus.uart_out_valid && p_uv && p_ur) viol++;
        if (bus.uart_out_valid && bus.inst_mem_in_valid) viol++;
        if ((load_completed || load_error) && (bus.uart_out_valid || bus.inst_mem_in_valid)) viol++;
        if (load_completed && load_error) viol++;
      end
      p_mv = bus.inst_mem_in_valid; p_mr = bus.inst_mem_in_ready;
      p_uv = bus.uart_out_valid;    p_ur = bus.uart_out_ready;
      p_addr = bus.inst_mem_in_addr; p_data = bus.inst_mem_in_data;
      p_len = bus.uart_buf_len;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tx_q.delete();
    exp_q.delete();
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic push_w(logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
  endtask

  task automatic expect_wr(logic [31:0] a, logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic finish_load(string name, bit ok, int wb, int nw);
    int cyc;
    cyc = 0;
    while (!(load_completed || load_error) && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    if (cyc >= 3000) begin
      n_checks++;
      $display("FAIL %s_timeout: got no completion or error within %0d cycles", name, cyc);
    end
    tick(5);
    check({name, "_completed"}, 32'(load_completed), 32'(ok));
    check({name, "_error"}, 32'(load_error), 32'(!ok));
    check({name, "_writes"}, 32'(n_writes - wb), 32'(nw));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_protocol"}, 32'(viol), 32'd0);
    if (ok) check({name, "_bytes_left"}, 32'(tx_q.size()), 32'd0);
  endtask

  task automatic wait_drained(string name);
    int cyc;
    cyc = 0;
    while ((tx_q.size() != 0 || bus.uart_out_valid || bus.uart_out_ready) && cyc < 200) begin
      tick(1);
      cyc++;
    end
    if (cyc >= 200) begin
      n_checks++;
      $display("FAIL %s_drain_timeout: got %0d bytes left required 0", name, tx_q.size());
    end
    tick(2);
  endtask

  initial begin
    int wb;
    int cnt;
    reset = 1'b1;
    tick(3);

    // Reset state
    check("rst_uart_valid", 32'(bus.uart_out_valid), 32'd0);
    check("rst_mem_valid", 32'(bus.inst_mem_in_valid), 32'd0);
    check("rst_addr", bus.inst_mem_in_addr, 32'd0);
    check("rst_data", bus.inst_mem_in_data, 32'd0);
    check("rst_completed", 32'(load_completed), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    reset = 1'b0;
    tick(1);

    // Two-word load
    do_reset();
    mem_delay = 0;
    wb = n_writes;
    expect_wr(32'h0, 32'h12345678);
    expect_wr(32'h4, 32'hDEADBEEF);
    push_w(32'd2); push_w(32'h12345678); push_w(32'hDEADBEEF);
`ifdef LOADER_CHECKSUM_EN
    push_w(32'hF0E21567);
`endif
    finish_load("two_words", 1'b1, wb, 2);

    // Empty program
    do_reset();
    wb = n_writes;
    push_w(32'd0);
`ifdef LOADER_CHECKSUM_EN
    push_w(32'd0);
`endif
    finish_load("empty", 1'b1, wb, 0);

    // Slow memory acknowledge
    do_reset();
    mem_delay = 5;
    wb = n_writes;
    expect_wr(32'h0, 32'hA5A5A5A5);
    expect_wr(32'h4, 32'h00000001);
    expect_wr(32'h8, 32'hFFFFFFFF);
    push_w(32'd3); push_w(32'hA5A5A5A5); push_w(32'h00000001); push_w(32'hFFFFFFFF);
`ifdef LOADER_CHECKSUM_EN
    push_w(32'hA5A5A5A5);
`endif
    finish_load("slow_mem", 1'b1, wb, 3);

    // UART starves mid-word
    do_reset();
    mem_delay = 1;
    wb = n_writes;
    expect_wr(32'h0, 32'hCAFEF00D);
    push_w(32'd1);
    tx_q.push_back(8'h0D); tx_q.push_back(8'hF0);
    wait_drained("starve");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.uart_out_valid) cnt++;
    end
    check("starve_no_request", 32'(cnt), 32'd0);
    tx_q.push_back(8'hFE); tx_q.push_back(8'hCA);
`ifdef LOADER_CHECKSUM_EN
    push_w(32'hCAFEF00D);
`endif
    finish_load("starve", 1'b1, wb, 1);

    // Program larger than instruction memory
    do_reset();
    mem_delay = 0;
    wb = n_writes;
    push_w(32'h00004001);
    push_w(32'h11111111);
    finish_load("too_big", 1'b0, wb, 0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum mismatch, then match
    do_reset();
    wb = n_writes;
    expect_wr(32'h0, 32'd1);
    expect_wr(32'h4, 32'd2);
    push_w(32'd2); push_w(32'd1); push_w(32'd2); push_w(32'd4);
    finish_load("cksum_bad", 1'b0, wb, 2);
    do_reset();
    wb = n_writes;
    expect_wr(32'h0, 32'd1);
    expect_wr(32'h4, 32'd2);
    push_w(32'd2); push_w(32'd1); push_w(32'd2); push_w(32'd3);
    finish_load("cksum_ok", 1'b1, wb, 2);
`endif

    // Reset mid-word, then a full load
    do_reset();
    wb = n_writes;
    push_w(32'd1);
    tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    wait_drained("midreset");
    do_reset();
    tick(5);
    check("midreset_no_write", 32'(n_writes - wb), 32'd0);
    check("midreset_completed", 32'(load_completed), 32'd0);
    expect_wr(32'h0, 32'hAABBCCDD);
    expect_wr(32'h4, 32'h01020304);
    push_w(32'd2); push_w(32'hAABBCCDD); push_w(32'h01020304);
`ifdef LOADER_CHECKSUM_EN
    push_w(32'hABBDCFE1);
`endif
    finish_load("restart", 1'b1, wb, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
